// File: rtl/cdb_buffered_pkg.sv
// Shared CDB types and default sizing for the buffered common data bus.
package cdb_buffered_pkg;

  localparam int NUM_FU_TOTAL     = 6;
  localparam int N                = 2;
  localparam int CDB_QDEPTH       = 2;
  localparam int CDB_STARVE_LIMIT = 4;
  localparam int TAG_W            = 6;
  localparam int DATA_W           = 32;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } CDB_ENTRY;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } CDB_EARLY_TAG_ENTRY;

  // Early tag view of a full CDB entry.
  function automatic CDB_EARLY_TAG_ENTRY early_of(input CDB_ENTRY e);
    CDB_EARLY_TAG_ENTRY t;
    t.valid = e.valid;
    t.tag   = e.tag;
    return t;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: circular buffer with head/tail pointers modulo QDEPTH.
module cdb_src_fifo
  import cdb_buffered_pkg::*;
#(
  parameter int QDEPTH = CDB_QDEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  CDB_ENTRY din,
  output CDB_ENTRY head,
  output logic     empty,
  output logic     full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  CDB_ENTRY      mem [QDEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is ignored; a pop of an empty FIFO is ignored.
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[head_ptr];

  // Pointer and occupancy control; clear behaves exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= next_ptr(tail_ptr);
      if (pop_ok)  head_ptr <= next_ptr(head_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care until made visible by count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail_ptr] <= din;
  end

endmodule

// File: rtl/cdb_buffered.sv
// Buffered multi-lane CDB: per-source FIFOs, two-pass starvation-aware
// fixed-priority selection, early tags this cycle, registered CDB next cycle.
module cdb_buffered
  import cdb_buffered_pkg::*;
#(
  parameter int NUM_SRC      = NUM_FU_TOTAL,
  parameter int LANES        = N,
  parameter int QDEPTH       = CDB_QDEPTH,
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic               [NUM_SRC-1:0]      src_valid,
  input  CDB_ENTRY           [NUM_SRC-1:0]      src_entry,
  output logic               [NUM_SRC-1:0]      src_ready,
  output CDB_EARLY_TAG_ENTRY [LANES-1:0]        early_tags,
  output CDB_ENTRY           [LANES-1:0]        cdb_output
);

  localparam int AW  = $clog2(STARVE_LIMIT + 1);
  localparam int LCW = $clog2(LANES + 1);
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [AW-1:0]  STARVE_AGE = AW'(STARVE_LIMIT);
  localparam logic [LCW-1:0] LANE_LIM   = LCW'(LANES);

  CDB_ENTRY [NUM_SRC-1:0] head;
  logic     [NUM_SRC-1:0] empty;
  logic     [NUM_SRC-1:0] full;
  logic     [NUM_SRC-1:0] eligible;
  logic     [NUM_SRC-1:0] starved;
  logic     [NUM_SRC-1:0] grant;
  logic     [AW-1:0]      age [NUM_SRC];
  logic     [LCW-1:0]     lane_cnt;
  CDB_ENTRY [LANES-1:0]   cdb_next_p0;
  CDB_ENTRY [LANES-1:0]   cdb_p1;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(
      .QDEPTH(QDEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (src_valid[i]),
      .pop   (grant[i]),
      .din   (src_entry[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
    assign starved[i] = (age[i] == STARVE_AGE);
  end

  // Ready depends only on current occupancy, never on this cycle's grant.
  assign src_ready = ~full;
  assign eligible  = ~empty;

  // ---- stage p0: selection (starved first, then the rest, ascending index)
  always_comb begin
    grant       = '0;
    cdb_next_p0 = '0;
    lane_cnt    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && starved[i] && (lane_cnt < LANE_LIM)) begin
        grant[i] = 1'b1;
        cdb_next_p0[lane_cnt[LIW-1:0]] = head[i];
        lane_cnt = lane_cnt + 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !starved[i] && (lane_cnt < LANE_LIM)) begin
        grant[i] = 1'b1;
        cdb_next_p0[lane_cnt[LIW-1:0]] = head[i];
        lane_cnt = lane_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_early
    assign early_tags[k] = early_of(cdb_next_p0[k]);
  end

  // Age tracking: count ungranted waiting cycles, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!eligible[i] || grant[i]) age[i] <= '0;
        else if (!starved[i])         age[i] <= age[i] + 1'b1;
      end
    end
  end

  // ---- stage p1: registered CDB broadcast
  always_ff @(posedge clock) begin
    if (reset || flush) cdb_p1 <= '0;
    else                cdb_p1 <= cdb_next_p0;
  end

  assign cdb_output = cdb_p1;

endmodule

// File: tb/tb_cdb_buffered.sv
// Bench for cdb_buffered: directed table, starvation sequence, random traffic
// against a queue-based reference model.
module tb_cdb_buffered;
  import cdb_buffered_pkg::*;

  localparam int NS = 6;
  localparam int NL = 2;
  localparam int QD = 2;
  localparam int SL = 4;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          flush;
  logic               [NS-1:0]   src_valid;
  CDB_ENTRY           [NS-1:0]   src_entry;
  logic               [NS-1:0]   src_ready;
  CDB_EARLY_TAG_ENTRY [NL-1:0]   early_tags;
  CDB_ENTRY           [NL-1:0]   cdb_output;

  cdb_buffered #(
    .NUM_SRC(NS), .LANES(NL), .QDEPTH(QD), .STARVE_LIMIT(SL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_entry  (src_entry),
    .src_ready  (src_ready),
    .early_tags (early_tags),
    .cdb_output (cdb_output)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [5:0] t);
    return {t, t, t, t, 8'hC3};
  endfunction

  function automatic CDB_ENTRY mk_entry(input logic [5:0] t);
    CDB_ENTRY e;
    e.valid = 1'b1;
    e.tag   = t;
    e.data  = mk_data(t);
    return e;
  endfunction

  // ---------------- reference model ----------------
  CDB_ENTRY mq [NS][$];
  int       mage [NS];
  CDB_ENTRY mcdb [NL];
  int       msel [NL];
  int       mnsel;
  bit       model_on = 1'b0;

  function automatic void model_clear();
    for (int i = 0; i < NS; i++) begin
      mq[i].delete();
      mage[i] = 0;
    end
    for (int k = 0; k < NL; k++) mcdb[k] = '0;
  endfunction

  function automatic void model_select();
    mnsel = 0;
    for (int k = 0; k < NL; k++) msel[k] = -1;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < NS; i++)
        if (mq[i].size() != 0 && mnsel < NL && ((pass == 0) == (mage[i] >= SL))) begin
          msel[mnsel] = i;
          mnsel++;
        end
  endfunction

  task automatic model_step();
    logic [NS-1:0] illegal;
    bit            gr [NS];
    if (reset) model_on = 1'b1;
    if (!model_on) return;
    illegal = '0;
    for (int i = 0; i < NS; i++) illegal[i] = src_valid[i] && (mq[i].size() >= QD);
    check("push_legal", 128'(illegal), 128'(0));
    if (reset || flush) begin
      model_clear();
      return;
    end
    model_select();
    for (int i = 0; i < NS; i++) gr[i] = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (k < mnsel) begin
        mcdb[k] = mq[msel[k]][0];
        gr[msel[k]] = 1'b1;
      end else begin
        mcdb[k] = '0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (mq[i].size() == 0 || gr[i]) mage[i] = 0;
      else if (mage[i] < SL)          mage[i] = mage[i] + 1;
      if (gr[i]) void'(mq[i].pop_front());
    end
    for (int i = 0; i < NS; i++)
      if (src_valid[i] && mq[i].size() < QD) mq[i].push_back(src_entry[i]);
  endtask

  task automatic model_check();
    logic [NS-1:0]               er;
    CDB_EARLY_TAG_ENTRY [NL-1:0] ee;
    CDB_ENTRY           [NL-1:0] ec;
    model_select();
    for (int i = 0; i < NS; i++) er[i] = (mq[i].size() < QD);
    for (int k = 0; k < NL; k++) begin
      ee[k] = '0;
      if (k < mnsel) begin
        ee[k].valid = 1'b1;
        ee[k].tag   = mq[msel[k]][0].tag;
      end
      ec[k] = mcdb[k];
    end
    check("model_ready", 128'(src_ready), 128'(er));
    check("model_early", 128'(early_tags), 128'(ee));
    check("model_cdb", 128'(cdb_output), 128'(ec));
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (model_on) model_check();
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst, fl, chk;
    logic [5:0] sv, tb, rdy;
    logic [1:0] ev;
    logic [5:0] et0, et1;
    logic [1:0] cv;
    logic [5:0] ct0, ct1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(input logic rst, fl, chk, input logic [5:0] sv, tb, rdy,
                               input logic [1:0] ev, input logic [5:0] et0, et1,
                               input logic [1:0] cv, input logic [5:0] ct0, ct1);
    vec_t v;
    v.rst = rst; v.fl = fl; v.chk = chk; v.sv = sv; v.tb = tb; v.rdy = rdy;
    v.ev = ev; v.et0 = et0; v.et1 = et1; v.cv = cv; v.ct0 = ct0; v.ct1 = ct1;
    return v;
  endfunction

  task automatic run_row(input vec_t v, input int idx);
    CDB_EARLY_TAG_ENTRY [NL-1:0] ee;
    CDB_ENTRY           [NL-1:0] ec;
    reset = v.rst; flush = v.fl; src_valid = v.sv;
    for (int i = 0; i < NS; i++) src_entry[i] = mk_entry(v.tb + 6'(i));
    @(negedge clock);
    if (v.chk) begin
      ee[0].valid = v.ev[0]; ee[0].tag = v.ev[0] ? v.et0 : 6'h0;
      ee[1].valid = v.ev[1]; ee[1].tag = v.ev[1] ? v.et1 : 6'h0;
      ec[0] = v.cv[0] ? mk_entry(v.ct0) : '0;
      ec[1] = v.cv[1] ? mk_entry(v.ct1) : '0;
      check($sformatf("row%0d_ready", idx), 128'(src_ready), 128'(v.rdy));
      check($sformatf("row%0d_early", idx), 128'(early_tags), 128'(ee));
      check($sformatf("row%0d_cdb", idx), 128'(cdb_output), 128'(ec));
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  t0, t1;
    int          pushed1;
    logic [5:0]  seen1[$];
    CDB_EARLY_TAG_ENTRY [NL-1:0] ee;

    reset = 1'b1; flush = 1'b0; src_valid = '0; src_entry = '0;

    //            rst fl chk sv     tb     rdy    ev     et0    et1    cv     ct0    ct1
    vt.push_back(row(1, 0, 0, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    // single push from src 3, tag 0x15
    vt.push_back(row(0, 0, 1, 6'h08, 6'h12, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b01, 6'h15, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b01, 6'h15, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    // srcs 0, 2, 5 together
    vt.push_back(row(0, 0, 1, 6'h25, 6'h20, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b11, 6'h20, 6'h22, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b01, 6'h25, 6'h00, 2'b11, 6'h20, 6'h22));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b01, 6'h25, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    // five entries buffered, then flush with a dropped push from src 5
    vt.push_back(row(0, 0, 1, 6'h1F, 6'h40, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 1, 1, 6'h20, 6'h40, 6'h3F, 2'b11, 6'h40, 6'h41, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    // reset mid-stream with a concurrent push from src 2
    vt.push_back(row(0, 0, 1, 6'h03, 6'h50, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(1, 0, 1, 6'h04, 6'h50, 6'h3F, 2'b11, 6'h50, 6'h51, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    // reset and flush together
    vt.push_back(row(0, 0, 1, 6'h01, 6'h60, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(1, 1, 1, 6'h02, 6'h60, 6'h3F, 2'b01, 6'h60, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));
    vt.push_back(row(0, 0, 1, 6'h00, 6'h00, 6'h3F, 2'b00, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00));

    for (int r = 0; r < vt.size(); r++) run_row(vt[r], r);

    // Starvation / back-pressure: srcs 0 and 1 push every cycle, src 4 holds one entry.
    t0 = 6'h08; t1 = 6'h18; pushed1 = 0;
    for (int c = 0; c < 14; c++) begin
      reset = 1'b0; flush = 1'b0; src_valid = '0; src_entry = '0;
      if (c < 8) begin
        if (src_ready[0]) begin src_valid[0] = 1'b1; src_entry[0] = mk_entry(t0); t0 = t0 + 6'd1; end
        if (src_ready[1]) begin src_valid[1] = 1'b1; src_entry[1] = mk_entry(t1); t1 = t1 + 6'd1; pushed1++; end
      end
      if (c == 0) begin src_valid[4] = 1'b1; src_entry[4] = mk_entry(6'h3C); end
      @(negedge clock);
      if (c >= 1 && c <= 4) begin
        ee[0].valid = 1'b1; ee[0].tag = 6'h08 + 6'(c - 1);
        ee[1].valid = 1'b1; ee[1].tag = 6'h18 + 6'(c - 1);
        check($sformatf("starve_wait_c%0d", c), 128'(early_tags), 128'(ee));
      end
      if (c == 5) begin
        ee[0].valid = 1'b1; ee[0].tag = 6'h3C;
        ee[1].valid = 1'b1; ee[1].tag = 6'h0C;
        check("starve_promote", 128'(early_tags), 128'(ee));
      end
      if (c == 6) begin
        check("src1_ready_low", 128'(src_ready[1]), 128'(0));
        ee[0].valid = 1'b1; ee[0].tag = 6'h0D;
        ee[1].valid = 1'b1; ee[1].tag = 6'h1C;
        check("after_promote", 128'(early_tags), 128'(ee));
      end
      if (c == 7) check("src1_ready_back", 128'(src_ready[1]), 128'(1));
      for (int k = 0; k < NL; k++)
        if (cdb_output[k].valid && cdb_output[k].tag >= 6'h18 && cdb_output[k].tag <= 6'h1F)
          seen1.push_back(cdb_output[k].tag);
      @(posedge clock); #1;
    end
    check("src1_count", 128'(seen1.size()), 128'(pushed1));
    for (int i = 0; i < seen1.size(); i++)
      check($sformatf("src1_order%0d", i), 128'(seen1[i]), 128'(6'h18 + 6'(i)));

    // Random traffic checked by the reference model.
    for (int c = 0; c < 2000; c++) begin
      int load;
      load  = 20 + 25 * (c / 500);
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NS; i++) begin
        src_entry[i].valid = 1'b1;
        src_entry[i].tag   = 6'($urandom);
        src_entry[i].data  = $urandom;
        src_valid[i] = src_ready[i] && ($urandom_range(0, 99) < load);
      end
      @(posedge clock); #1;
    end

    reset = 1'b0; flush = 1'b0; src_valid = '0;
    repeat (6) begin
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
